// File: rtl/mtm_alu_deserializer.sv
// Serial packet deserializer for the MTM ALU: collects DATA_PKTS data bytes into
// operands B/A, closes each frame with a command packet, and flags data-count and framing errors.
module mtm_alu_deserializer #(
  parameter int unsigned DATA_PKTS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  CMD,
  output logic        data_valid,
  output logic        err_data,
  output logic        err_frame
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BCNT_W  = 3;
  localparam int unsigned PCNT_W  = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLAG    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RESYNC  = 3'd4;

  localparam logic [PCNT_W-1:0] PCNT_MAX  = '1;
  localparam logic [PCNT_W-1:0] PCNT_FULL = PCNT_W'(DATA_PKTS);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [BCNT_W-1:0] bit_cnt;
  logic [PCNT_W-1:0] pkt_cnt;
  logic [BYTE_W-1:0] byte_reg;
  logic [DATA_W-1:0] data_reg;
  logic              is_cmd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; RESYNC requires a high bit before a new start is accepted
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (!sin) next_state = S_FLAG;
      S_FLAG:    next_state = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == BCNT_W'(7)) next_state = S_STOP;
      S_STOP:    next_state = sin ? S_IDLE : S_RESYNC;
      S_RESYNC:  if (sin) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Datapath and registered one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      pkt_cnt    <= '0;
      byte_reg   <= '0;
      data_reg   <= '0;
      is_cmd     <= 1'b0;
      A          <= '0;
      B          <= '0;
      CMD        <= '0;
      data_valid <= 1'b0;
      err_data   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      err_data   <= 1'b0;
      err_frame  <= 1'b0;
      case (state)
        S_FLAG: begin
          is_cmd  <= sin;
          bit_cnt <= '0;
        end
        S_PAYLOAD: begin
          byte_reg <= {byte_reg[BYTE_W-2:0], sin};
          bit_cnt  <= bit_cnt + BCNT_W'(1);
        end
        S_STOP: begin
          if (sin) begin
            if (!is_cmd) begin
              data_reg <= {data_reg[DATA_W-BYTE_W-1:0], byte_reg};
              if (pkt_cnt != PCNT_MAX) pkt_cnt <= pkt_cnt + PCNT_W'(1);
            end else begin
              CMD     <= byte_reg;
              pkt_cnt <= '0;
              if (pkt_cnt == PCNT_FULL) begin
                B          <= data_reg[63:32];
                A          <= data_reg[31:0];
                data_valid <= 1'b1;
              end else begin
                err_data <= 1'b1;
              end
            end
          end else begin
            err_frame <= 1'b1;
            pkt_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: valid, short, long, gapped and broken frames plus resets.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  CMD;
  logic        data_valid;
  logic        err_data;
  logic        err_frame;

  int unsigned cyc = 0;
  int unsigned dv_cnt = 0;
  int unsigned ed_cnt = 0;
  int unsigned ef_cnt = 0;
  int unsigned dv_cyc = 0;
  int unsigned mutex_bad = 0;
  int unsigned t0;
  int          tests = 0;
  int          fails = 0;

  mtm_alu_deserializer #(.DATA_PKTS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .A          (A),
    .B          (B),
    .CMD        (CMD),
    .data_valid (data_valid),
    .err_data   (err_data),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles of each flag, sampled 1 time unit after the edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (err_data)  ed_cnt++;
    if (err_frame) ef_cnt++;
    if ((32'(data_valid) + 32'(err_data) + 32'(err_frame)) > 1) mutex_bad++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    dv_cnt = 0;
    ed_cnt = 0;
    ef_cnt = 0;
    dv_cyc = 0;
  endtask

  // Drive one bit, sampled at the next rising edge
  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_tail(input logic flag, input logic [7:0] data, input logic stop);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic send_pkt(input logic flag, input logic [7:0] data);
    send_bit(1'b0);
    send_tail(flag, data, 1'b1);
  endtask

  // B bytes (MSB first), A bytes, then the command; optional idle gap before every packet
  task automatic send_frame(input logic [31:0] b_w, input logic [31:0] a_w,
                            input logic [7:0] cmd, input int gap, input bit skip_start);
    logic [63:0] d;
    d = {b_w, a_w};
    for (int i = 0; i < 8; i++) begin
      idle(gap);
      if (i == 0 && skip_start) send_tail(1'b0, d[63-8*i -: 8], 1'b1);
      else send_pkt(1'b0, d[63-8*i -: 8]);
    end
    idle(gap);
    send_pkt(1'b1, cmd);
  endtask

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_A", 64'(A), 64'h0);
    check("rst_B", 64'(B), 64'h0);
    check("rst_CMD", 64'(CMD), 64'h0);
    check("rst_flags", 64'({data_valid, err_data, err_frame}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back valid frame
    clr_cnt();
    t0 = cyc;
    send_frame(32'h0000_0003, 32'h0000_0005, 8'h12, 0, 1'b0);
    idle(3);
    check("nogap_dv", 64'(dv_cnt), 64'd1);
    check("nogap_errs", 64'(ed_cnt + ef_cnt), 64'd0);
    check("nogap_A", 64'(A), 64'h5);
    check("nogap_B", 64'(B), 64'h3);
    check("nogap_CMD", 64'(CMD), 64'h12);
    check("nogap_lat", 64'(dv_cyc - t0), 64'd100);

    // Same frame with 3 idle cycles before every packet
    clr_cnt();
    t0 = cyc;
    send_frame(32'h0000_0003, 32'h0000_0005, 8'h12, 3, 1'b0);
    idle(3);
    check("gap_dv", 64'(dv_cnt), 64'd1);
    check("gap_A", 64'(A), 64'h5);
    check("gap_B", 64'(B), 64'h3);
    check("gap_CMD", 64'(CMD), 64'h12);
    check("gap_lat", 64'(dv_cyc - t0), 64'd127);

    // Short frame, then a full one
    clr_cnt();
    for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'hEE);
    send_pkt(1'b1, 8'h34);
    idle(3);
    check("short_ed", 64'(ed_cnt), 64'd1);
    check("short_dv", 64'(dv_cnt), 64'd0);
    check("short_CMD", 64'(CMD), 64'h34);
    check("short_A", 64'(A), 64'h5);
    check("short_B", 64'(B), 64'h3);
    clr_cnt();
    send_frame(32'h1122_3344, 32'h5566_7788, 8'h56, 0, 1'b0);
    idle(3);
    check("after_short_dv", 64'(dv_cnt), 64'd1);
    check("after_short_ed", 64'(ed_cnt), 64'd0);
    check("after_short_A", 64'(A), 64'h5566_7788);
    check("after_short_B", 64'(B), 64'h1122_3344);
    check("after_short_CMD", 64'(CMD), 64'h56);

    // Framing error after 3 good packets, line held low, then a valid frame
    clr_cnt();
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h99);
    send_bit(1'b0);
    send_tail(1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    idle(1);
    check("ferr_ef_early", 64'(ef_cnt), 64'd1);
    check("ferr_A_held", 64'(A), 64'h5566_7788);
    send_frame(32'hCAFE_BABE, 32'h0BAD_F00D, 8'h77, 0, 1'b0);
    idle(3);
    check("ferr_ef", 64'(ef_cnt), 64'd1);
    check("ferr_dv", 64'(dv_cnt), 64'd1);
    check("ferr_ed", 64'(ed_cnt), 64'd0);
    check("ferr_A", 64'(A), 64'h0BAD_F00D);
    check("ferr_B", 64'(B), 64'hCAFE_BABE);
    check("ferr_CMD", 64'(CMD), 64'h77);

    // Asynchronous mid-frame reset, released with sin low as the first start bit
    clr_cnt();
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hFF);
    send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_A", 64'(A), 64'h0);
    check("mrst_B", 64'(B), 64'h0);
    check("mrst_CMD", 64'(CMD), 64'h0);
    repeat (2) @(negedge clk);
    check("mrst_flags", 64'({data_valid, err_data, err_frame}), 64'h0);
    sin   = 1'b0;
    rst_n = 1'b1;
    send_frame(32'h0102_0304, 32'h0506_0708, 8'h9A, 0, 1'b1);
    idle(3);
    check("mrst_dv", 64'(dv_cnt), 64'd1);
    check("mrst_errs", 64'(ed_cnt + ef_cnt), 64'd0);
    check("mrst_newA", 64'(A), 64'h0506_0708);
    check("mrst_newB", 64'(B), 64'h0102_0304);
    check("mrst_newCMD", 64'(CMD), 64'h9A);

    // Over-long frames: 9, 16 and 24 data packets (24 would alias to 8 without saturation)
    for (int n = 0; n < 3; n++) begin
      int np;
      np = (n == 0) ? 9 : (n == 1) ? 16 : 24;
      clr_cnt();
      for (int i = 0; i < np; i++) send_pkt(1'b0, 8'(i + 1));
      send_pkt(1'b1, 8'(8'hA0 + n));
      idle(3);
      check($sformatf("long%0d_ed", np), 64'(ed_cnt), 64'd1);
      check($sformatf("long%0d_dv", np), 64'(dv_cnt), 64'd0);
      check($sformatf("long%0d_A", np), 64'(A), 64'h0506_0708);
      check($sformatf("long%0d_CMD", np), 64'(CMD), 64'(8'hA0 + n));
    end

    check("flags_exclusive", 64'(mutex_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
